// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Serves imemREN/imemaddr with a
// same-cycle hit and refills two-word blocks through a wait-based read port.
module icache #(
  parameter int unsigned NSETS = 8,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 29 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1
  } state_t;

  state_t            state_q, state_d;
  logic [28:0]       fill_addr_q, fill_addr_d;
  logic [31:0]       word0_q, word0_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic [NSETS-1:0]  valid_q;
  logic              fill_we;

  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [31:0]       data_q [NSETS][WORDS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req_off;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              unused_addr_bits;

  assign req_idx  = imemaddr[2+IDX_W:3];
  assign req_tag  = imemaddr[31:3+IDX_W];
  assign req_off  = imemaddr[2];
  assign fill_idx = fill_addr_q[IDX_W-1:0];
  assign fill_tag = fill_addr_q[28:IDX_W];

  assign unused_addr_bits = ^imemaddr[1:0];

  assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A hit is only reported from IDLE so a pending fill is never overtaken.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    if (state_q == IDLE && lookup_hit) begin
      ihit     = 1'b1;
      imemload = data_q[req_idx][req_off];
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    word0_d      = word0_q;
    miss_count_d = miss_count_q;
    fill_we      = 1'b0;
    iREN         = 1'b0;
    iaddr        = '0;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          fill_addr_d  = imemaddr[31:3];
          miss_count_d = miss_count_q + 32'd1;
          state_d      = FILL0;
        end
      end
      FILL0: begin
        iREN  = 1'b1;
        iaddr = {fill_addr_q, 3'b000};
        if (!iwait) begin
          word0_d = iload;
          state_d = FILL1;
        end
      end
      FILL1: begin
        iREN  = 1'b1;
        iaddr = {fill_addr_q, 3'b100};
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      word0_q      <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      word0_q      <= word0_d;
      miss_count_q <= miss_count_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]     <= fill_tag;
      data_q[fill_idx][0] <= word0_q;
      data_q[fill_idx][1] <= iload;
    end
  end

  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hit data and memory
// addresses; a negedge monitor checks them as the DUT presents them.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] miss_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hit_q[$];
  logic [31:0] addr_q[$];
  int unsigned w0 = 0, w1 = 0, wait_left = 0;

  icache #(.NSETS(8), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .miss_count(miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11111111;
      32'h4:   return 32'h22222222;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Memory: w0 busy cycles before the first word, w1 before the second.
  assign iwait = (wait_left != 0);
  assign iload = iwait ? 32'hDEADBEEF : memval(iaddr);
  always @(posedge CLK) begin
    if (!iREN)               wait_left <= w0;
    else if (wait_left != 0) wait_left <= wait_left - 1;
    else                     wait_left <= w1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (ihit) begin
        if (hit_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_hit: got imemload=%h expected no hit", imemload);
        end else begin
          chk("hit_data", imemload, hit_q.pop_front());
        end
      end else begin
        chk("load_zero_no_hit", imemload, 32'h0);
      end
      if (iREN) begin
        if (addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_iREN: got iaddr=%h expected iREN=0", iaddr);
        end else begin
          chk("iaddr", iaddr, addr_q[0]);
          if (!iwait) void'(addr_q.pop_front());
        end
      end else begin
        chk("iaddr_idle", iaddr, 32'h0);
      end
    end
  end

  // Starts at posedge+1 with the request driven; returns cycles with ihit=0.
  task automatic wait_hit(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (ihit) got = 1;
      else begin
        lat++;
        @(posedge CLK); #1;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL hit_timeout: got no ihit in 40 cycles expected a hit");
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic access(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat);
    int lat;
    imemaddr = a;
    imemREN  = 1'b1;
    hit_q.push_back(d);
    wait_hit(lat);
    chk({nm, "_latency"}, lat, exp_lat);
  endtask

  task automatic do_reset();
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int lat;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0;
    #2;
    chk("rst_ihit", ihit, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_miss_count", miss_count, 0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // cold miss, then spatial hit in the same block
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    access("cold", 32'h0, 32'h11111111, 3);
    chk("cold_miss_count", miss_count, 1);
    access("spatial", 32'h4, 32'h22222222, 0);
    chk("spatial_miss_count", miss_count, 1);

    // conflict eviction on set 0
    addr_q.push_back(32'h40); addr_q.push_back(32'h44);
    access("conflict", 32'h40, 32'h0040FFBF, 3);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    access("reread0", 32'h0, 32'h11111111, 3);
    chk("conflict_miss_count", miss_count, 3);

    // memory wait states: 4 in FILL0, 2 in FILL1
    w0 = 4; w1 = 2;
    addr_q.push_back(32'h8); addr_q.push_back(32'hC);
    access("wait", 32'h8, 32'h0008FFF7, 9);
    w0 = 0; w1 = 0;
    access("wait_word1", 32'hC, 32'h000CFFF3, 0);
    chk("wait_miss_count", miss_count, 4);

    // address change during FILL0: 0x10 fill completes, then 0x20 fills
    do_reset();
    chk("reset2_miss_count", miss_count, 0);
    addr_q.push_back(32'h10); addr_q.push_back(32'h14);
    addr_q.push_back(32'h20); addr_q.push_back(32'h24);
    hit_q.push_back(32'h0020FFDF);
    imemaddr = 32'h10; imemREN = 1'b1;
    @(posedge CLK); #1;
    imemaddr = 32'h20;
    wait_hit(lat);
    chk("switch_latency", lat, 5);
    chk("switch_miss_count", miss_count, 2);
    access("switch_old_block", 32'h14, 32'h0014FFEB, 0);

    // imemREN=0 on a cached address: no hit, no fill
    imemaddr = 32'h14; imemREN = 1'b0;
    @(negedge CLK);
    chk("noren_ihit", ihit, 0);
    @(posedge CLK); #1;
    chk("noren_iREN", iREN, 0);
    chk("noren_miss_count", miss_count, 2);

    // reset while waiting in FILL1
    w1 = 3;
    addr_q.push_back(32'h30); addr_q.push_back(32'h34);
    imemaddr = 32'h30; imemREN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_reset_iREN", iREN, 1);
    nRST = 1'b0;
    addr_q.delete();
    #1;
    chk("midfill_rst_iREN", iREN, 0);
    chk("midfill_rst_ihit", ihit, 0);
    chk("midfill_rst_iaddr", iaddr, 0);
    chk("midfill_rst_miss_count", miss_count, 0);
    imemREN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1; w1 = 0;
    @(posedge CLK); #1;
    addr_q.push_back(32'h30); addr_q.push_back(32'h34);
    access("after_rst", 32'h30, 32'h0030FFCF, 3);
    chk("after_rst_miss_count", miss_count, 1);
    addr_q.push_back(32'h10); addr_q.push_back(32'h14);
    access("after_rst_invalid", 32'h10, 32'h0010FFEF, 3);
    chk("after_rst_miss_count2", miss_count, 2);

    repeat (2) @(posedge CLK);
    chk("hit_q_drained", hit_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
